bp_cce_cfg_cmd_arbiter: RTL and testbench
=========================================

BP_CCE_CFG_CMD_ARBITER -- requirements
Module: bp_cce_cfg_cmd_arbiter

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg; sets paddr/block/lce widths and cce_mem_msg_width_lp (W).
REQ-002 SHALL have parameter num_req_p, default 2; number of config requesters, range 2..8.
REQ-003 SHALL have parameter max_credits_p, default 4; maximum outstanding commands on the config network.
REQ-004 SHALL have port clk_i, input, 1; the single clock.
REQ-005 SHALL have port reset_i, input, 1; reset, synchronous and active-high.
REQ-006 SHALL have port req_cmd_i, input, num_req_p*W; requester i occupies slice [i*W +: W].
REQ-007 SHALL have port req_cmd_v_i, input, num_req_p; per-requester command valid.
REQ-008 SHALL have port req_cmd_yumi_o, output, num_req_p; per-requester command consumed.
REQ-009 SHALL have port req_resp_o, output, W; response data, broadcast to all requesters.
REQ-010 SHALL have port req_resp_v_o, output, num_req_p; one-hot response valid.
REQ-011 SHALL have port req_resp_ready_i, input, num_req_p; per-requester response ready.
REQ-012 SHALL have port io_cmd_o, output, W; command to the config network.
REQ-013 SHALL have port io_cmd_v_o, output, 1; command valid.
REQ-014 SHALL have port io_cmd_yumi_i, input, 1; network accepts the command.
REQ-015 SHALL have port io_resp_i, input, W; response from the network.
REQ-016 SHALL have port io_resp_v_i, input, 1; response valid.
REQ-017 SHALL have port io_resp_ready_o, output, 1; arbiter can accept the response.
REQ-018 SHALL have port credits_empty_o, output, 1; high when no commands are outstanding.

Function
REQ-019 All messages SHALL be single-beat; one transfer per cycle per channel.
REQ-020 Arbitration SHALL be round-robin; the search starts at index rr_ptr_r+1 (mod num_req_p).
REQ-021 io_cmd_v_o SHALL be high when some req_cmd_v_i is high and credit_cnt_r < max_credits_p.
REQ-022 io_cmd_o SHALL equal the command of the granted requester.
REQ-023 Grant SHALL lock while io_cmd_v_o is high without io_cmd_yumi_i; grant and io_cmd_o stay stable until accepted.
REQ-024 req_cmd_yumi_o[g] SHALL be high exactly when io_cmd_yumi_i is high; g is the granted index.
REQ-025 On acceptance: rr_ptr_r <= g; the lock releases the next cycle.
REQ-026 Credit counter credit_cnt_r, range 0..max_credits_p:
 - +1 on io_cmd_yumi_i;
 - -1 on io_resp_v_i & io_resp_ready_o;
 - both in one cycle: unchanged.
REQ-027 At credit_cnt_r == max_credits_p, io_cmd_v_o SHALL be low; a response in the same cycle SHALL NOT enable issue until the next cycle.
REQ-028 An ID FIFO (depth max_credits_p, width clog2(num_req_p)) SHALL push g on io_cmd_yumi_i and pop on response handshake.
REQ-029 Simultaneous push and pop SHALL be legal when full or empty, provided the counter permits the push.
REQ-030 io_resp_ready_o SHALL equal FIFO non-empty & req_resp_ready_i[head].
REQ-031 req_resp_v_o[head] SHALL equal io_resp_v_i & FIFO non-empty; all other bits 0; req_resp_o = io_resp_i combinationally.
REQ-032 A response arriving with the FIFO empty SHALL NOT be accepted (io_resp_ready_o = 0).
REQ-033 credits_empty_o SHALL be high when credit_cnt_r == 0.
REQ-034 Command-to-network latency SHALL be 0 cycles (combinational path from req to io_cmd).

Reset
REQ-035 While reset_i is high, at the clock edge: credit_cnt_r=0, FIFO empty, rr_ptr_r=num_req_p-1 (requester 0 wins first), lock cleared.
REQ-036 Outputs during and after reset: io_cmd_v_o=0, req_cmd_yumi_o=0, req_resp_v_o=0, io_resp_ready_o=0, credits_empty_o=1.
REQ-037 Reset mid-transaction SHALL discard all outstanding credits and IDs; no response is routed afterward.

Verification
REQ-038 Requesters 0 and 1 both valid continuously, yumi every cycle, responses immediate -> grants alternate 0,1,0,1; each response goes to its issuer.
REQ-039 max_credits_p=4, no responses, req 0 valid -> exactly 4 accepts, then io_cmd_v_o=0; one response -> one more issue on the following cycle.
REQ-040 Grant to req 1, io_cmd_yumi_i withheld 3 cycles while req 0 raises valid -> io_cmd_o holds req 1's data; req 1 yumi'd first.
REQ-041 Issue order 1,0,1 then 3 responses with req_resp_ready_i[0]=0 for 2 cycles -> first response to 1; second stalls (io_resp_ready_o=0) then goes to 0; third to 1.
REQ-042 Issue and response in the same cycle at credit_cnt_r=2 -> count stays 2, FIFO occupancy stays 2.
REQ-043 Reset with 3 outstanding -> credits_empty_o=1 the next cycle; a late io_resp_v_i is not accepted.

Source files
------------

// File: rtl/bp_cce_cfg_cmd_arbiter.sv
// Arbitrates config commands from several requesters onto one credit-limited
// config network and routes each response back to the requester that issued it.

package bp_cce_cfg_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_unicore_cfg,
    e_bp_multicore_4_cfg
  } bp_params_e;

  function automatic int paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_unicore_cfg:     return 40;
      e_bp_multicore_4_cfg: return 40;
      default:              return 40;
    endcase
  endfunction

  function automatic int lce_id_width(input bp_params_e cfg);
    case (cfg)
      e_bp_unicore_cfg:     return 1;
      e_bp_multicore_4_cfg: return 3;
      default:              return 4;
    endcase
  endfunction

  // Message = type(4) + size(3) + paddr + lce id + one 64-bit config data word.
  function automatic int cce_mem_msg_width(input bp_params_e cfg);
    return 4 + 3 + paddr_width(cfg) + lce_id_width(cfg) + 64;
  endfunction

endpackage

module bp_cce_cfg_cmd_arbiter
  import bp_cce_cfg_cmd_arbiter_pkg::*;
#(
  parameter bp_params_e bp_params_p   = e_bp_default_cfg,
  parameter int         num_req_p     = 2,
  parameter int         max_credits_p = 4,
  localparam int        cce_mem_msg_width_lp = cce_mem_msg_width(bp_params_p)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,

  input  logic [num_req_p*cce_mem_msg_width_lp-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]                      req_cmd_v_i,
  output logic [num_req_p-1:0]                      req_cmd_yumi_o,

  output logic [cce_mem_msg_width_lp-1:0]           req_resp_o,
  output logic [num_req_p-1:0]                      req_resp_v_o,
  input  logic [num_req_p-1:0]                      req_resp_ready_i,

  output logic [cce_mem_msg_width_lp-1:0]           io_cmd_o,
  output logic                                      io_cmd_v_o,
  input  logic                                      io_cmd_yumi_i,

  input  logic [cce_mem_msg_width_lp-1:0]           io_resp_i,
  input  logic                                      io_resp_v_i,
  output logic                                      io_resp_ready_o,

  output logic                                      credits_empty_o
);

  localparam int W     = cce_mem_msg_width_lp;
  localparam int id_w  = $clog2(num_req_p);
  localparam int cnt_w = $clog2(max_credits_p + 1);
  localparam int ptr_w = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;

  typedef enum logic {
    e_arb_open,
    e_arb_locked
  } arb_state_e;

  arb_state_e        state_q, state_d;
  logic [id_w-1:0]   grant_q, grant_d;
  logic [id_w-1:0]   rr_ptr_q, rr_ptr_d;
  logic [cnt_w-1:0]  credit_q, credit_d;
  logic [ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
  logic [id_w-1:0]   id_mem_q [max_credits_p];
  logic [id_w-1:0]   id_mem_d [max_credits_p];

  logic [W-1:0]      cmd_arr [num_req_p];
  logic [id_w-1:0]   arb_idx;
  logic              arb_found;
  logic [id_w-1:0]   cand;
  logic [id_w-1:0]   grant_idx;
  logic              cmd_pending;
  logic              credit_avail;
  logic              issue;
  logic              fifo_nonempty;
  logic [id_w-1:0]   head_id;
  logic              resp_hs;

  for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
    assign cmd_arr[i] = req_cmd_i[i*W +: W];
  end

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(max_credits_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  // Round-robin search from rr_ptr_q+1; walking k downward makes the
  // nearest valid requester the last (winning) assignment.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = '0;
    for (int k = num_req_p; k >= 1; k--) begin
      cand = id_w'((int'(rr_ptr_q) + k) % num_req_p);
      if (req_cmd_v_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_idx    = (state_q == e_arb_locked) ? grant_q : arb_idx;
    cmd_pending  = (state_q == e_arb_locked) ? req_cmd_v_i[grant_q] : arb_found;
    credit_avail = (credit_q < cnt_w'(max_credits_p));
    io_cmd_v_o   = ~reset_i & cmd_pending & credit_avail;
    io_cmd_o     = cmd_arr[grant_idx];
    issue        = io_cmd_v_o & io_cmd_yumi_i;

    req_cmd_yumi_o = '0;
    if (issue) begin
      req_cmd_yumi_o[grant_idx] = 1'b1;
    end
  end

  // Grant lock: an offered but unaccepted command keeps its requester.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      e_arb_open: begin
        if (issue) begin
          rr_ptr_d = arb_idx;
        end else if (io_cmd_v_o) begin
          state_d = e_arb_locked;
          grant_d = arb_idx;
        end
      end
      e_arb_locked: begin
        if (issue) begin
          rr_ptr_d = grant_q;
          state_d  = e_arb_open;
        end else if (!io_cmd_v_o) begin
          state_d = e_arb_open;
        end
      end
      default: state_d = e_arb_open;
    endcase
  end

  // The ID FIFO occupancy always equals the credit count, so the counter
  // doubles as the FIFO fill level.
  always_comb begin
    fifo_nonempty   = (credit_q != '0);
    head_id         = id_mem_q[rd_ptr_q];
    io_resp_ready_o = ~reset_i & fifo_nonempty & req_resp_ready_i[head_id];
    resp_hs         = io_resp_v_i & io_resp_ready_o;
    req_resp_o      = io_resp_i;

    req_resp_v_o = '0;
    if (~reset_i & io_resp_v_i & fifo_nonempty) begin
      req_resp_v_o[head_id] = 1'b1;
    end

    credits_empty_o = reset_i | (credit_q == '0);
  end

  always_comb begin
    credit_d = credit_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    id_mem_d = id_mem_q;

    case ({issue, resp_hs})
      2'b10:   credit_d = credit_q + cnt_w'(1);
      2'b01:   credit_d = credit_q - cnt_w'(1);
      default: credit_d = credit_q;
    endcase

    if (issue) begin
      id_mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
    end
    if (resp_hs) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_arb_open;
      grant_q  <= '0;
      rr_ptr_q <= id_w'(num_req_p - 1);
      credit_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ID storage needs no reset; entries are only read when the count says valid.
  always_ff @(posedge clk_i) begin
    id_mem_q <= id_mem_d;
  end

endmodule

// File: tb/tb_bp_cce_cfg_cmd_arbiter.sv
// Bench for bp_cce_cfg_cmd_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based model of outstanding commands.

module tb_bp_cce_cfg_cmd_arbiter;
  import bp_cce_cfg_cmd_arbiter_pkg::*;

  localparam bp_params_e CFG = e_bp_default_cfg;
  localparam int W   = cce_mem_msg_width(CFG);
  localparam int N   = 3;
  localparam int MAX = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_i = 1'b1;
  logic [N*W-1:0]   req_cmd_i = '0;
  logic [N-1:0]     req_cmd_v_i = '0;
  logic [N-1:0]     req_cmd_yumi_o;
  logic [W-1:0]     req_resp_o;
  logic [N-1:0]     req_resp_v_o;
  logic [N-1:0]     req_resp_ready_i = '0;
  logic [W-1:0]     io_cmd_o;
  logic             io_cmd_v_o;
  logic             io_cmd_yumi_i = 1'b0;
  logic [W-1:0]     io_resp_i = '0;
  logic             io_resp_v_i = 1'b0;
  logic             io_resp_ready_o;
  logic             credits_empty_o;

  bp_cce_cfg_cmd_arbiter #(
    .bp_params_p   (CFG),
    .num_req_p     (N),
    .max_credits_p (MAX)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .req_cmd_i        (req_cmd_i),
    .req_cmd_v_i      (req_cmd_v_i),
    .req_cmd_yumi_o   (req_cmd_yumi_o),
    .req_resp_o       (req_resp_o),
    .req_resp_v_o     (req_resp_v_o),
    .req_resp_ready_i (req_resp_ready_i),
    .io_cmd_o         (io_cmd_o),
    .io_cmd_v_o       (io_cmd_v_o),
    .io_cmd_yumi_i    (io_cmd_yumi_i),
    .io_resp_i        (io_resp_i),
    .io_resp_v_i      (io_resp_v_i),
    .io_resp_ready_o  (io_resp_ready_o),
    .credits_empty_o  (credits_empty_o)
  );

  int checks = 0;
  int errors = 0;

  // reference model: requester-held commands and the in-order list of issuers
  logic [W-1:0] data [N];
  logic [N-1:0] pend = '0;
  int           out_q[$];
  int           last_g = N - 1;
  bit           locked = 1'b0;
  int           lock_g = 0;

  // last sampled DUT outputs, for the directed checks
  logic         obs_cmd_v, obs_resp_ready, obs_empty;
  logic [N-1:0] obs_yumi, obs_resp_v;
  logic [W-1:0] obs_cmd;

  function automatic logic [W-1:0] rnd_w();
    logic [255:0] t;
    for (int j = 0; j < 8; j++) t[j*32 +: 32] = $urandom();
    return t[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver + model: one clock cycle of stimulus, checks before the edge
  task automatic step(input bit rst, input logic [N-1:0] raise, input bit take,
                      input bit rv, input logic [N-1:0] rdy);
    int           g;
    int           head;
    bit           ev;
    bit           erdy;
    logic [N-1:0] ey;
    logic [N-1:0] erv;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (raise[i] && !pend[i]) begin
        pend[i] = 1'b1;
        data[i] = rnd_w();
      end
    end
    g = -1;
    if (locked) g = lock_g;
    else begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && pend[(last_g + k) % N]) g = (last_g + k) % N;
      end
    end
    ev = 1'b0;
    if (!rst && g >= 0) ev = pend[g] && (out_q.size() < MAX);
    head = (out_q.size() > 0) ? out_q[0] : -1;
    ey = '0;
    if (ev && take) ey[g] = 1'b1;
    erv  = '0;
    erdy = 1'b0;
    if (!rst && head >= 0) begin
      erdy = rdy[head];
      if (rv) erv[head] = 1'b1;
    end

    reset_i     = rst;
    req_cmd_v_i = pend;
    for (int i = 0; i < N; i++) req_cmd_i[i*W +: W] = data[i];
    io_cmd_yumi_i    = ev && take;
    io_resp_v_i      = rv;
    io_resp_i        = rnd_w();
    req_resp_ready_i = rdy;
    #1;
    chk("io_cmd_v_o", W'(io_cmd_v_o), W'(ev));
    if (ev) chk("io_cmd_o", io_cmd_o, data[g]);
    chk("req_cmd_yumi_o", W'(req_cmd_yumi_o), W'(ey));
    chk("req_resp_v_o", W'(req_resp_v_o), W'(erv));
    chk("io_resp_ready_o", W'(io_resp_ready_o), W'(erdy));
    chk("credits_empty_o", W'(credits_empty_o), W'(rst || out_q.size() == 0));
    chk("req_resp_o", req_resp_o, io_resp_i);
    obs_cmd_v      = io_cmd_v_o;
    obs_cmd        = io_cmd_o;
    obs_yumi       = req_cmd_yumi_o;
    obs_resp_v     = req_resp_v_o;
    obs_resp_ready = io_resp_ready_o;
    obs_empty      = credits_empty_o;

    @(posedge clk);
    if (rst) begin
      out_q.delete();
      last_g = N - 1;
      locked = 1'b0;
      pend   = '0;
    end else begin
      if (rv && erdy) void'(out_q.pop_front());
      if (ev && take) begin
        out_q.push_back(g);
        last_g = g;
        locked = 1'b0;
        pend[g] = 1'b0;
      end else begin
        locked = ev;
        lock_g = g;
      end
    end
  endtask

  logic [N-1:0] all_rdy;
  logic [W-1:0] held;
  int           alt [6];

  initial begin
    all_rdy = '1;
    alt = '{0, 1, 0, 1, 0, 1};

    // reset with noisy inputs: every output quiet
    step(1, 3'b011, 1, 1, all_rdy);
    step(1, 3'b111, 1, 1, all_rdy);
    chk("reset_cmd_v", W'(obs_cmd_v), W'(1'b0));
    chk("reset_empty", W'(obs_empty), W'(1'b1));

    // two requesters always valid, immediate responses: grants alternate
    for (int s = 0; s < 6; s++) begin
      step(0, 3'b011, 1, 1, all_rdy);
      chk("alternate_grant", W'(obs_yumi), W'(3'b001 << alt[s]));
    end

    // credit limit: four accepts, stall, one response frees one slot
    step(1, 3'b000, 0, 0, all_rdy);
    for (int s = 0; s < 4; s++) begin
      step(0, 3'b001, 1, 0, all_rdy);
      chk("credit_fill_yumi", W'(obs_yumi), W'(3'b001));
    end
    step(0, 3'b001, 1, 0, all_rdy);
    chk("credit_full_v", W'(obs_cmd_v), W'(1'b0));
    step(0, 3'b001, 1, 1, all_rdy);
    chk("full_resp_ready", W'(obs_resp_ready), W'(1'b1));
    chk("full_same_cycle_v", W'(obs_cmd_v), W'(1'b0));
    step(0, 3'b001, 1, 0, all_rdy);
    chk("after_resp_issue", W'(obs_yumi), W'(3'b001));

    // grant lock: req 1 held for 3 cycles while req 0 raises valid
    step(1, 3'b000, 0, 0, all_rdy);
    step(0, 3'b010, 0, 0, all_rdy);
    held = data[1];
    for (int s = 0; s < 3; s++) begin
      step(0, 3'b011, 0, 0, all_rdy);
      chk("lock_cmd_hold", obs_cmd, held);
    end
    step(0, 3'b011, 1, 0, all_rdy);
    chk("lock_yumi_req1", W'(obs_yumi), W'(3'b010));

    // issue order 1,0,1 then responses with requester 0 briefly not ready
    step(0, 3'b001, 1, 0, all_rdy);
    chk("order_second_req0", W'(obs_yumi), W'(3'b001));
    step(0, 3'b010, 1, 0, all_rdy);
    chk("order_third_req1", W'(obs_yumi), W'(3'b010));
    step(0, 3'b000, 0, 1, 3'b110);
    chk("resp1_route", W'(obs_resp_v), W'(3'b010));
    for (int s = 0; s < 2; s++) begin
      step(0, 3'b000, 0, 1, 3'b110);
      chk("resp2_stall", W'(obs_resp_ready), W'(1'b0));
    end
    step(0, 3'b000, 0, 1, all_rdy);
    chk("resp2_route", W'(obs_resp_v), W'(3'b001));
    chk("resp2_ready", W'(obs_resp_ready), W'(1'b1));
    step(0, 3'b000, 0, 1, all_rdy);
    chk("resp3_route", W'(obs_resp_v), W'(3'b010));

    // issue and response in one cycle at two outstanding
    step(0, 3'b100, 1, 0, all_rdy);
    step(0, 3'b100, 1, 0, all_rdy);
    step(0, 3'b001, 1, 1, all_rdy);
    chk("simul_issue", W'(obs_yumi), W'(3'b001));
    chk("simul_resp", W'(obs_resp_ready), W'(1'b1));
    step(0, 3'b000, 0, 1, all_rdy);
    step(0, 3'b000, 0, 1, all_rdy);
    chk("simul_still_one", W'(obs_empty), W'(1'b0));
    step(0, 3'b000, 0, 1, all_rdy);
    chk("simul_drained", W'(obs_empty), W'(1'b1));
    chk("simul_no_accept", W'(obs_resp_ready), W'(1'b0));

    // reset with three outstanding discards them
    for (int s = 0; s < 3; s++) step(0, 3'b111, 1, 0, all_rdy);
    step(1, 3'b000, 0, 1, all_rdy);
    step(0, 3'b000, 0, 1, all_rdy);
    chk("post_reset_empty", W'(obs_empty), W'(1'b1));
    chk("post_reset_no_ready", W'(obs_resp_ready), W'(1'b0));
    chk("post_reset_no_route", W'(obs_resp_v), W'(3'b000));

    // random traffic
    for (int s = 0; s < 600; s++) begin
      step($urandom_range(0, 99) == 0, N'($urandom()), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, N'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
